// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - instruction channel between the instruction source and the sequencer
interface alu_op_sequencer_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle controller driving a combinational ALU from a 4-entry register file
// Each accepted instruction runs rep+1 ALU iterations, writing the result back into rd every cycle.
module alu_op_sequencer #(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave instr_if,
    input  logic              ld_en_i,
    input  logic [1:0]        ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [1:0]        alu_ctrl_o,
    input  logic [DATA_W:0]   alu_result_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              flag_c_o,
    input  logic [1:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic [1:0]        rd_q, rd_d;
    logic [1:0]        rs_q, rs_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [1:0]        count_q, count_d;
    logic              flag_c_q, flag_c_d;
    logic              instr_ready;

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        ctrl_d      = ctrl_q;
        count_d     = count_q;
        flag_c_d    = flag_c_q;
        instr_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A register load takes priority; the instruction waits a cycle.
                instr_ready = ~ld_en_i;
                if (ld_en_i) begin
                    regs_d[ld_addr_i] = ld_data_i;
                end else if (instr_if.instr_valid) begin
                    ctrl_d  = instr_if.instr[7:6];
                    rd_d    = instr_if.instr[5:4];
                    rs_d    = instr_if.instr[3:2];
                    count_d = instr_if.instr[1:0];
                    state_d = S_OPER;
                end
            end
            S_OPER: begin
                regs_d[rd_q] = alu_result_i[DATA_W-1:0];
                flag_c_d     = alu_result_i[DATA_W];
                if (count_q == 2'd0) begin
                    state_d = S_DONE;
                end else begin
                    count_d = count_q - 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            rd_q     <= 2'd0;
            rs_q     <= 2'd0;
            ctrl_q   <= 2'd0;
            count_q  <= 2'd0;
            flag_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            rd_q     <= rd_d;
            rs_q     <= rs_d;
            ctrl_q   <= ctrl_d;
            count_q  <= count_d;
            flag_c_q <= flag_c_d;
        end
    end

    // Operands read the live register file so each iteration sees the previous write-back.
    assign alu_a_o              = regs_q[rd_q];
    assign alu_b_o              = regs_q[rs_q];
    assign alu_ctrl_o           = ctrl_q;
    assign instr_if.instr_ready = instr_ready;
    assign busy_o               = (state_q != S_IDLE);
    assign done_o               = (state_q == S_DONE);
    assign flag_c_o             = flag_c_q;
    assign dbg_data_o           = regs_q[dbg_addr_i];

endmodule
